w_align_stage: RTL
==================

# w_align_stage

Write-path byte aligner placed between the VLSU store port and the system AXI interface, mirroring the read-path aligner on the R channel. The VLSU emits W data packed from byte 0 regardless of the AW address. This block rotates each beat to the AW byte offset, carries spill-over bytes into the next beat, and regenerates strobes. It emits an extra flush beat when the packed stream crosses one more bus word than it supplied. AR/R/B pass through untouched; AW is tracked in an in-order FIFO.

## Interface
- AxiDataWidth, 0: bus width in bits; N = AxiDataWidth/8 bytes, power of two, ≥ 8.
- AxiAddrWidth, 0: address width.
- axi_req_t, axi_resp_t, axi_addr_t, axi_data_t, axi_strb_t, logic: AXI bundle and field types.
- NumTrackers, 8: depth of the AW tracker FIFO (power of two).
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- axi_req_i  in  axi_req_t  VLSU requests (AW, packed W, AR, r_ready, b_ready).
- axi_resp_o  out  axi_resp_t  responses to VLSU.
- axi_req_o  out  axi_req_t  aligned requests to system.
- axi_resp_i  in  axi_resp_t  system responses.
- err_o  out  1  one-cycle pulse on a burst beat-count mismatch.

## Operation
- Passthrough: ar, ar_valid, ar_ready, r, r_valid, r_ready, b, b_valid, b_ready, aw payload.
- AW gating: axi_req_o.aw_valid = aw_valid_i && !full; axi_resp_o.aw_ready = aw_ready_i && !full. On handshake, push {off = aw.addr[log2 N-1:0], len = aw.len} into the tracker and advance the write pointer (wraps at NumTrackers-1).
- W is accepted only when the tracker is non-empty. The head entry governs the burst.
- Rotation: input byte i goes to output byte (i+off) mod N. Bytes with i+off ≥ N go to the carry register at byte i+off-N.
- Output beat = {carry bytes [off-1:0], rotated input bytes [N-1:off]}. Strobes are merged the same way. The first beat of a burst has carry strobe 0.
- FSM states:
  - IDLE to STREAM: tracker non-empty.
  - STREAM to FLUSH: input last accepted with a non-zero carry strobe (off ≠ 0 and a spill exists).
  - STREAM to IDLE: input last accepted with a zero carry strobe; that output beat carries w.last=1.
  - FLUSH to IDLE: the flush beat is accepted. The flush beat carries carry data, carry strobe, and w.last=1.
- Leaving STREAM or FLUSH on a last handshake pops the tracker, clears the carry, and resets the beat counter.
- Upstream w_ready = downstream w_ready in STREAM, and 0 in IDLE and FLUSH.
- off = 0: carry is always empty, and data/strobe pass unchanged.
- Beat counter (8 bit) counts output handshakes. On the output last handshake, err_o pulses if count+1 ≠ len+1. Data-driven last is still emitted, and the burst still retires.
- AW push and tracker pop in the same cycle leave the count unchanged. A full tracker with a simultaneous pop still reports full that cycle (no bypass).

## Timing
- Reset values: w_valid 0, w.last 0, strb 0, err_o 0, tracker empty, pointers 0, carry 0, state IDLE. Passthrough outputs follow their inputs.
- AW-to-first-W: W is not forwarded in the AW handshake cycle; earliest is the next cycle.
- Without the pipe macro: STREAM beats are combinational. w_valid_o = w_valid_i, and latency is 0. The flush beat is presented in the cycle after the input last handshake.
- w_valid_o and the payload must stay stable while w_ready_i is low. Carry updates only on an output handshake.
- Reset mid-burst: all state is discarded immediately. No partial beat is emitted after reset release.

## Configuration
- W_ALIGN_PIPE_EN defined: a stream register (valid/ready, full throughput) is inserted after the merge stage. Output latency is 1 cycle, and upstream w_ready comes from the register's ready. err_o is registered with the beat.
- W_ALIGN_PIPE_EN undefined: the output is combinational from the input and carry as described; no extra register.

## Test plan
- N=16, addr 0x1000, len 3, 4 full beats: 4 output beats, identical data, strb 0xFFFF, last on the 4th, err_o 0.
- N=16, addr 0x1004, len 2, 2 input beats strb 0xFFFF: 3 output beats with strb 0xFFF0, 0xFFFF, 0x000F.
  - Upstream w_ready is 0 during the flush; last is on the 3rd beat.
  - Byte 0 of input beat 0 appears at output byte 4.
- N=16, addr 0x100C, len 0, 1 input beat strb 0x000F: 1 output beat strb 0xF000, no flush, last=1.
- Push 8 AWs with no W: the 9th sees aw_ready=0 and aw_valid_o=0. After the first burst's last handshake, the 9th is accepted the next cycle.
- Mid-burst w_ready_i held low 5 cycles at addr 0x1004: payload and strb are stable, no byte is lost or duplicated, and the carry is unchanged.
- addr 0x1004, len 0, 1 full input beat: 2 output beats; err_o pulses with the 2nd (last) beat.
- Reset asserted mid-burst: w_valid_o is 0 immediately and the tracker is empty. A new aligned burst after release passes cleanly.

Source files
------------

// File: rtl/w_align_stage.sv
// -----------------------------------------------------------------------------
// w_align_stage
//
// Write-path byte aligner between the VLSU store port and the system AXI port.
// The VLSU packs every W beat from byte 0 whatever the AW address is. This
// stage rotates each beat to the AW byte offset and carries the spill-over
// bytes into the next beat. It also regenerates the strobes, and adds one
// flush beat when the rotated stream needs one more bus word than it supplied.
// AR, R and B are passed through unchanged. Each accepted AW pushes
// {offset, len} into an in-order tracker FIFO, and the head entry governs the
// W burst currently streaming.
//
// Optional feature macro: W_ALIGN_PIPE_EN
//   defined   : a full-throughput valid/ready register follows the merge
//               stage. Output latency is 1 cycle and err_o is carried with
//               the beat.
//   undefined : the output is combinational from the input and the carry.
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   axi_req_i   VLSU requests (AW, packed W, AR, r_ready, b_ready)
//   axi_resp_o  responses to the VLSU
//   axi_req_o   aligned requests to the system
//   axi_resp_i  system responses
//   err_o       one-cycle pulse when a burst's output beat count differs
//               from len+1
// -----------------------------------------------------------------------------

package w_align_pkg;

   localparam int unsigned AxiDataWidthDef = 128;
   localparam int unsigned AxiAddrWidthDef = 32;

   typedef logic [AxiAddrWidthDef-1:0]   axi_addr_t;
   typedef logic [AxiDataWidthDef-1:0]   axi_data_t;
   typedef logic [AxiDataWidthDef/8-1:0] axi_strb_t;

   typedef struct packed {
      logic [3:0] id;
      axi_addr_t  addr;
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
   } axi_ax_t;

   typedef struct packed {
      axi_data_t data;
      axi_strb_t strb;
      logic      last;
   } axi_w_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } axi_b_t;

   typedef struct packed {
      logic [3:0] id;
      axi_data_t  data;
      logic [1:0] resp;
      logic       last;
   } axi_r_t;

   typedef struct packed {
      axi_ax_t aw;
      logic    aw_valid;
      axi_w_t  w;
      logic    w_valid;
      logic    b_ready;
      axi_ax_t ar;
      logic    ar_valid;
      logic    r_ready;
   } axi_req_t;

   typedef struct packed {
      logic   aw_ready;
      logic   w_ready;
      axi_b_t b;
      logic   b_valid;
      logic   ar_ready;
      axi_r_t r;
      logic   r_valid;
   } axi_resp_t;

endpackage

// state  | meaning
// IDLE   | no burst in progress; upstream W blocked, no output beat
// STREAM | head burst streaming; rotated input merged with carry
// FLUSH  | input last taken with spill left; emit carry as final beat
module w_align_stage #(
   parameter int unsigned AxiDataWidth = w_align_pkg::AxiDataWidthDef,
   parameter int unsigned AxiAddrWidth = w_align_pkg::AxiAddrWidthDef,
   parameter type         axi_req_t    = w_align_pkg::axi_req_t,
   parameter type         axi_resp_t   = w_align_pkg::axi_resp_t,
   parameter type         axi_addr_t   = w_align_pkg::axi_addr_t,
   parameter type         axi_data_t   = w_align_pkg::axi_data_t,
   parameter type         axi_strb_t   = w_align_pkg::axi_strb_t,
   parameter int unsigned NumTrackers  = 8
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  axi_req_t  axi_req_i,
   output axi_resp_t axi_resp_o,
   output axi_req_t  axi_req_o,
   input  axi_resp_t axi_resp_i,
   output logic      err_o
);

   localparam int unsigned NumBytes = AxiDataWidth / 8;
   localparam int unsigned OffW     = $clog2(NumBytes);
   localparam int unsigned PtrW     = $clog2(NumTrackers);
   localparam logic [PtrW:0] TrkDepth = (PtrW+1)'(NumTrackers);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

   state_e state_q;

   // ---------------------------------------------------------------- tracker
   logic [OffW-1:0] trk_off_q [NumTrackers];
   logic [7:0]      trk_len_q [NumTrackers];
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [PtrW:0]   cnt_q;
   logic            trk_full, trk_empty, trk_push, trk_pop;
   axi_addr_t       aw_addr;
   logic [OffW-1:0] aw_off;
   logic [OffW-1:0] head_off;
   logic [7:0]      head_len;

   assign aw_addr   = axi_req_i.aw.addr;
   // NumBytes is a power of two, so this reduces to the low address bits.
   assign aw_off    = OffW'(aw_addr % AxiAddrWidth'(NumBytes));
   assign trk_full  = (cnt_q == TrkDepth);
   assign trk_empty = (cnt_q == '0);
   assign trk_push  = axi_req_i.aw_valid && axi_resp_i.aw_ready && !trk_full;
   assign head_off  = trk_off_q[rptr_q];
   assign head_len  = trk_len_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (trk_push) begin
         trk_off_q[wptr_q] <= aw_off;
         trk_len_q[wptr_q] <= axi_req_i.aw.len;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (trk_push) wptr_q <= wptr_q + 1'b1;
         if (trk_pop)  rptr_q <= rptr_q + 1'b1;
         if (trk_push && !trk_pop)      cnt_q <= cnt_q + 1'b1;
         else if (!trk_push && trk_pop) cnt_q <= cnt_q - 1'b1;
      end
   end

   // ----------------------------------------------------------- merge stage
   // The input is shifted into a double-width window. The low half fills
   // output bytes [N-1:off], and the high half is the spill carried into the
   // next beat at bytes [off-1:0].
   axi_data_t                 carry_data_q;
   axi_strb_t                 carry_strb_q;
   logic [7:0]                beat_cnt_q;
   logic [2*AxiDataWidth-1:0] wide_data;
   logic [2*NumBytes-1:0]     wide_strb;
   axi_data_t                 spill_data;
   axi_strb_t                 spill_strb;
   axi_data_t                 m_data;
   axi_strb_t                 m_strb;
   logic                      m_valid, m_ready, m_last, m_err, m_hs;

   assign wide_data  = {{AxiDataWidth{1'b0}}, axi_req_i.w.data} << {head_off, 3'b000};
   assign wide_strb  = {{NumBytes{1'b0}}, axi_req_i.w.strb} << head_off;
   assign spill_data = wide_data[2*AxiDataWidth-1:AxiDataWidth];
   assign spill_strb = wide_strb[2*NumBytes-1:NumBytes];

   always_comb begin
      m_valid = 1'b0;
      m_data  = '0;
      m_strb  = '0;
      m_last  = 1'b0;
      case (state_q)
         STREAM: begin
            m_valid = axi_req_i.w_valid;
            m_data  = wide_data[AxiDataWidth-1:0] | carry_data_q;
            m_strb  = wide_strb[NumBytes-1:0] | carry_strb_q;
            m_last  = axi_req_i.w.last && (spill_strb == '0);
         end
         FLUSH: begin
            m_valid = 1'b1;
            m_data  = carry_data_q;
            m_strb  = carry_strb_q;
            m_last  = 1'b1;
         end
         default: ;
      endcase
   end

   assign m_hs    = m_valid && m_ready;
   // Modulo-256 compare, so len 255 with 256 beats matches.
   assign m_err   = (beat_cnt_q != head_len);
   assign trk_pop = m_hs && m_last;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         carry_data_q <= '0;
         carry_strb_q <= '0;
         beat_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!trk_empty) state_q <= STREAM;
            end
            STREAM: begin
               if (m_hs) begin
                  beat_cnt_q   <= beat_cnt_q + 8'd1;
                  carry_data_q <= spill_data;
                  carry_strb_q <= spill_strb;
                  if (axi_req_i.w.last) begin
                     if (spill_strb != '0) begin
                        state_q <= FLUSH;
                     end else begin
                        state_q      <= IDLE;
                        carry_data_q <= '0;
                        carry_strb_q <= '0;
                        beat_cnt_q   <= '0;
                     end
                  end
               end
            end
            FLUSH: begin
               if (m_hs) begin
                  state_q      <= IDLE;
                  carry_data_q <= '0;
                  carry_strb_q <= '0;
                  beat_cnt_q   <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ output side
   logic      out_valid, out_last;
   axi_data_t out_data;
   axi_strb_t out_strb;

`ifdef W_ALIGN_PIPE_EN
   logic      pv_q, plast_q, perr_q;
   axi_data_t pdata_q;
   axi_strb_t pstrb_q;

   assign m_ready = !pv_q || axi_resp_i.w_ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pv_q    <= 1'b0;
         pdata_q <= '0;
         pstrb_q <= '0;
         plast_q <= 1'b0;
         perr_q  <= 1'b0;
      end else if (m_ready) begin
         pv_q <= m_valid;
         if (m_valid) begin
            pdata_q <= m_data;
            pstrb_q <= m_strb;
            plast_q <= m_last;
            perr_q  <= m_last && m_err;
         end
      end
   end

   assign out_valid = pv_q;
   assign out_data  = pdata_q;
   assign out_strb  = pstrb_q;
   assign out_last  = plast_q;
   assign err_o     = pv_q && axi_resp_i.w_ready && perr_q;
`else
   assign m_ready   = axi_resp_i.w_ready;
   assign out_valid = m_valid;
   assign out_data  = m_data;
   assign out_strb  = m_strb;
   assign out_last  = m_last;
   assign err_o     = m_hs && m_last && m_err;
`endif

   always_comb begin
      axi_req_o          = axi_req_i;
      axi_req_o.aw_valid = axi_req_i.aw_valid && !trk_full;
      axi_req_o.w_valid  = out_valid;
      axi_req_o.w.data   = out_data;
      axi_req_o.w.strb   = out_strb;
      axi_req_o.w.last   = out_last;

      axi_resp_o          = axi_resp_i;
      axi_resp_o.aw_ready = axi_resp_i.aw_ready && !trk_full;
      axi_resp_o.w_ready  = (state_q == STREAM) && m_ready;
   end

endmodule
